// File: rtl/im_fetch_ctrl.sv
// im_fetch_ctrl: frame sequencer for the level item-memory lookup.
// Takes one quantized level per feature, drives the combinational item
// memory, and captures the returned hypervector. It then presents that
// hypervector to the binder/bundler tagged with its feature index.
// Out-of-range levels are replaced by a zero hypervector and counted.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | no frame active; waits for start
// S_WAIT_IN | in_ready high; waiting for the next quantized level
// S_LOOKUP  | im_en high; item memory data captured at the closing edge
// S_EMIT    | out_valid high; tagged HV held until out_ready
// S_DONE    | one-cycle done pulse, then back to idle
module im_fetch_ctrl #(
    parameter int NUM_FEATURES = 16,
    parameter int LEVEL_W      = 4,
    parameter int HV_W         = 10,
    parameter int MAX_LEVEL    = 9,
    parameter int IDX_W        = $clog2(NUM_FEATURES)
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               start,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LEVEL_W-1:0] in_qlevel,
    output logic [LEVEL_W-1:0] im_qlevel,
    output logic               im_en,
    input  logic [HV_W-1:0]    im_level_hv,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [HV_W-1:0]    out_hv,
    output logic [IDX_W-1:0]   out_idx,
    output logic               out_last,
    output logic               err_level,
    output logic [7:0]         err_count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT_IN = 3'd1,
        S_LOOKUP  = 3'd2,
        S_EMIT    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [LEVEL_W-1:0] MAX_LVL  = LEVEL_W'(MAX_LEVEL);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_FEATURES - 1);

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   cnt;
    logic               lvl_oor;

    assign lvl_oor  = (im_qlevel > MAX_LVL);
    assign out_idx  = cnt;
    assign out_last = (cnt == LAST_IDX);

    // State register
    always_ff @(posedge clk) begin
        if (!nrst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; abort overrides every other transition
    always_comb begin
        state_nxt = state;
        if (abort && (state != S_IDLE)) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (start)     state_nxt = S_WAIT_IN;
                S_WAIT_IN: if (in_valid)  state_nxt = S_LOOKUP;
                S_LOOKUP:                 state_nxt = S_EMIT;
                S_EMIT:    if (out_ready) state_nxt = out_last ? S_DONE : S_WAIT_IN;
                S_DONE:                   state_nxt = S_IDLE;
                default:                  state_nxt = S_IDLE;
            endcase
        end
    end

    // Moore outputs decoded from the current state
    always_comb begin
        busy      = (state != S_IDLE);
        done      = 1'b0;
        in_ready  = 1'b0;
        im_en     = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_WAIT_IN: in_ready  = 1'b1;
            S_LOOKUP:  im_en     = 1'b1;
            S_EMIT:    out_valid = 1'b1;
            S_DONE:    done      = 1'b1;
            default:   ;
        endcase
    end

    // Datapath: level/HV capture, feature counter and error tracking.
    // An aborting cycle updates nothing, so counter and errors survive abort.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            cnt       <= '0;
            im_qlevel <= '0;
            out_hv    <= '0;
            err_level <= 1'b0;
            err_count <= 8'd0;
        end else if (state == S_IDLE) begin
            if (start) begin
                cnt       <= '0;
                err_level <= 1'b0;
                err_count <= 8'd0;
            end
        end else if (!abort) begin
            case (state)
                S_WAIT_IN: begin
                    if (in_valid) im_qlevel <= in_qlevel;
                end
                S_LOOKUP: begin
                    if (lvl_oor) begin
                        out_hv    <= '0;
                        err_level <= 1'b1;
                        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                    end else begin
                        out_hv <= im_level_hv;
                    end
                end
                S_EMIT: begin
                    if (out_ready && !out_last) cnt <= cnt + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// Directed bench for im_fetch_ctrl: nominal frame, out-of-range levels,
// backpressure, abort, mid-frame reset, ignored start, and error saturation
// on a second 300-feature instance.
module tb_im_fetch_ctrl;

    logic        clk = 1'b0;
    logic        nrst;
    always #5 clk = ~clk;

    // 16-feature instance
    logic        start, abort, busy, done;
    logic        in_valid, in_ready;
    logic [3:0]  in_qlevel, im_qlevel;
    logic        im_en;
    logic [9:0]  im_level_hv;
    logic        out_valid, out_ready;
    logic [9:0]  out_hv;
    logic [3:0]  out_idx;
    logic        out_last, err_level;
    logic [7:0]  err_count;

    // 300-feature instance for counter saturation
    logic        s_start, s_abort, s_busy, s_done;
    logic        s_in_valid, s_in_ready;
    logic [3:0]  s_in_qlevel, s_im_qlevel;
    logic        s_im_en;
    logic [9:0]  s_im_level_hv;
    logic        s_out_valid, s_out_ready;
    logic [9:0]  s_out_hv;
    logic [8:0]  s_out_idx;
    logic        s_out_last, s_err_level;
    logic [7:0]  s_err_count;

    // Item memory model: level k maps to hypervector 0x00k
    assign im_level_hv   = {6'd0, im_qlevel};
    assign s_im_level_hv = {6'd0, s_im_qlevel};

    im_fetch_ctrl dut (
        .clk(clk), .nrst(nrst), .start(start), .abort(abort),
        .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
        .in_qlevel(in_qlevel), .im_qlevel(im_qlevel), .im_en(im_en),
        .im_level_hv(im_level_hv), .out_valid(out_valid), .out_ready(out_ready),
        .out_hv(out_hv), .out_idx(out_idx), .out_last(out_last),
        .err_level(err_level), .err_count(err_count)
    );

    im_fetch_ctrl #(.NUM_FEATURES(300)) dut_sat (
        .clk(clk), .nrst(nrst), .start(s_start), .abort(s_abort),
        .busy(s_busy), .done(s_done), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_qlevel(s_in_qlevel), .im_qlevel(s_im_qlevel), .im_en(s_im_en),
        .im_level_hv(s_im_level_hv), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_hv(s_out_hv), .out_idx(s_out_idx), .out_last(s_out_last),
        .err_level(s_err_level), .err_count(s_err_count)
    );

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    logic [3:0] lv [16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_nominal;
        for (int i = 0; i < 16; i++) lv[i] = 4'((i < 10) ? i : i - 10);
    endtask

    // Runs one frame on the 16-feature instance. bp_idx: feature held off by
    // out_ready=0 for 5 cycles; abort_idx: feature at which abort is raised in
    // EMIT; stray: pulse start in WAIT_IN (idx 2) and EMIT (idx 4).
    task automatic run_frame(input int bp_idx, input int abort_idx, input bit stray,
                             input int exp_done);
        logic [9:0] exp_hv;
        cyc   = 0;
        start = 1'b1;
        tick;
        start = 1'b0;
        check("busy_after_start", 32'(busy), 1);
        check("err_level_cleared", 32'(err_level), 0);
        check("err_count_cleared", 32'(err_count), 0);
        for (int k = 0; k < 16; k++) begin
            check("in_ready_wait", 32'(in_ready), 1);
            check("out_valid_wait", 32'(out_valid), 0);
            in_qlevel = lv[k];
            in_valid  = 1'b1;
            if (stray && k == 2) start = 1'b1;
            tick;
            in_valid = 1'b0;
            start    = 1'b0;
            check("im_en_lookup", 32'(im_en), 1);
            check("im_qlevel", 32'(im_qlevel), 32'(lv[k]));
            check("in_ready_lookup", 32'(in_ready), 0);
            tick;
            exp_hv = (lv[k] > 4'd9) ? 10'd0 : {6'd0, lv[k]};
            check("out_valid_emit", 32'(out_valid), 1);
            check("out_hv", 32'(out_hv), 32'(exp_hv));
            check("out_idx", 32'(out_idx), k);
            check("out_last", 32'(out_last), (k == 15) ? 1 : 0);
            check("im_en_emit", 32'(im_en), 0);
            if (k == bp_idx) begin
                out_ready = 1'b0;
                repeat (5) begin
                    tick;
                    check("bp_out_valid", 32'(out_valid), 1);
                    check("bp_out_hv", 32'(out_hv), 32'(exp_hv));
                    check("bp_out_idx", 32'(out_idx), k);
                    check("bp_in_ready", 32'(in_ready), 0);
                end
                out_ready = 1'b1;
            end
            if (k == abort_idx) begin
                abort = 1'b1;
                tick;
                abort = 1'b0;
                check("abort_busy", 32'(busy), 0);
                check("abort_out_valid", 32'(out_valid), 0);
                check("abort_in_ready", 32'(in_ready), 0);
                check("abort_done", 32'(done), 0);
                tick;
                check("abort_no_done", 32'(done), 0);
                check("abort_idx_kept", 32'(out_idx), k);
                return;
            end
            if (stray && k == 4) start = 1'b1;
            tick;
            start = 1'b0;
        end
        check("done_pulse", 32'(done), 1);
        check("done_cycle", cyc, exp_done);
        tick;
        check("done_one_cycle", 32'(done), 0);
        check("idle_busy", 32'(busy), 0);
    endtask

    initial begin
        start = 0; abort = 0; in_valid = 0; in_qlevel = 0; out_ready = 1;
        s_start = 0; s_abort = 0; s_in_valid = 1; s_in_qlevel = 4'd15; s_out_ready = 1;
        nrst = 0;
        tick;
        tick;
        nrst = 1;
        tick;

        // reset state
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_im_en", 32'(im_en), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_last", 32'(out_last), 0);
        check("rst_err_level", 32'(err_level), 0);
        check("rst_im_qlevel", 32'(im_qlevel), 0);
        check("rst_out_hv", 32'(out_hv), 0);
        check("rst_out_idx", 32'(out_idx), 0);
        check("rst_err_count", 32'(err_count), 0);
        check("rst_sat_err_count", 32'(s_err_count), 0);

        // nominal frame
        set_nominal;
        run_frame(-1, -1, 1'b0, 49);
        check("nominal_err_count", 32'(err_count), 0);
        check("nominal_err_level", 32'(err_level), 0);

        // out-of-range levels 10 and 15, boundary level 9
        set_nominal;
        lv[2] = 4'd10;
        lv[5] = 4'd15;
        lv[8] = 4'd9;
        run_frame(-1, -1, 1'b0, 49);
        check("oor_err_level", 32'(err_level), 1);
        check("oor_err_count", 32'(err_count), 2);

        // backpressure at idx 3 (errors from previous frame cleared on start)
        set_nominal;
        run_frame(3, -1, 1'b0, 54);

        // abort in EMIT at idx 7, with one error seen earlier in the frame
        set_nominal;
        lv[1] = 4'd12;
        run_frame(-1, 7, 1'b0, 0);
        check("abort_err_level_kept", 32'(err_level), 1);
        check("abort_err_count_kept", 32'(err_count), 1);

        // restart after abort from idx 0 with errors cleared
        set_nominal;
        run_frame(-1, -1, 1'b0, 49);

        // reset during LOOKUP
        start = 1'b1;
        tick;
        start     = 1'b0;
        in_qlevel = 4'd12;
        in_valid  = 1'b1;
        tick;
        in_valid = 1'b0;
        check("mid_lookup_im_en", 32'(im_en), 1);
        nrst = 1'b0;
        tick;
        nrst = 1'b1;
        check("mrst_busy", 32'(busy), 0);
        check("mrst_im_en", 32'(im_en), 0);
        check("mrst_out_valid", 32'(out_valid), 0);
        check("mrst_im_qlevel", 32'(im_qlevel), 0);
        check("mrst_out_hv", 32'(out_hv), 0);
        check("mrst_err_count", 32'(err_count), 0);
        check("mrst_err_level", 32'(err_level), 0);
        run_frame(-1, -1, 1'b0, 49);

        // start pulses while busy are ignored
        set_nominal;
        run_frame(-1, -1, 1'b1, 49);

        // saturation on the 300-feature instance, every level out of range
        begin
            bit seen = 1'b0;
            s_start = 1'b1;
            tick;
            s_start = 1'b0;
            for (int i = 0; i < 1200 && !seen; i++) begin
                if (s_done) seen = 1'b1;
                else tick;
            end
            check("sat_done_seen", 32'(seen), 1);
            check("sat_err_count", 32'(s_err_count), 255);
            check("sat_err_level", 32'(s_err_level), 1);
            check("sat_last_idx", 32'(s_out_idx), 299);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/im_fetch_ctrl.md
# im_fetch_ctrl

Frame sequencer for the level item-memory lookup in the sparse HDC encoder front end. It accepts one quantized level per feature from the quantizer over a valid/ready handshake and drives the combinational item memory's `qlevel`/`en` inputs. It captures the returned level hypervector and presents it, tagged with its feature index, to the downstream binder/bundler over a second valid/ready handshake. It counts features per frame, flags out-of-range levels and signals frame completion.

## Interface
- `NUM_FEATURES`, default 16: features per frame. Must be ≥ 2.
- `LEVEL_W`, default 4: width of the quantized level.
- `HV_W`, default 10: hypervector width.
- `MAX_LEVEL`, default 9: highest valid level code.
- `IDX_W`, default `$clog2(NUM_FEATURES)`: feature index width.

Ports:
- `clk`  in  1  rising-edge clock
- `nrst`  in  1  reset, synchronous, active-low
- `start`  in  1  begin a frame; honoured only in IDLE
- `abort`  in  1  cancel the current frame; return to IDLE
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at frame completion
- `in_valid`  in  1  quantizer level valid
- `in_ready`  out  1  controller can accept a level
- `in_qlevel`  in  LEVEL_W  quantized level
- `im_qlevel`  out  LEVEL_W  level address to item memory
- `im_en`  out  1  item memory enable
- `im_level_hv`  in  HV_W  item memory data, combinational from `im_qlevel`
- `out_valid`  out  1  tagged HV valid
- `out_ready`  in  1  downstream accepts
- `out_hv`  out  HV_W  captured level HV
- `out_idx`  out  IDX_W  feature index, 0..NUM_FEATURES-1
- `out_last`  out  1  high with the final feature of the frame
- `err_level`  out  1  sticky: an out-of-range level was seen this frame
- `err_count`  out  8  count of out-of-range levels this frame, saturating at 255

## Operation
- States: IDLE, WAIT_IN, LOOKUP, EMIT, DONE.
- IDLE → WAIT_IN on `start`. On that transition: feature counter ← 0, `err_level` ← 0, `err_count` ← 0.
- WAIT_IN: `in_ready`=1. On `in_valid`:
  - register `in_qlevel` into `im_qlevel`.
  - go to LOOKUP.
- LOOKUP: `im_en`=1 for exactly this cycle.
  - Capture `im_level_hv` into `out_hv` at the closing edge.
  - If `im_qlevel` > MAX_LEVEL, force `out_hv` ← 0 regardless of memory data, set `err_level`, and increment `err_count` (saturating).
  - Go to EMIT.
- EMIT: `out_valid`=1. `out_hv`, `out_idx`, `out_last` are held stable until `out_ready`.
  - On handshake with `out_last`=0: counter +1, go to WAIT_IN.
  - On handshake with `out_last`=1: go to DONE.
- `out_last` = (counter == NUM_FEATURES-1).
- DONE: `done`=1 for one cycle, then IDLE. `err_level` and `err_count` hold until the next `start`.
- `abort`, sampled in any non-IDLE state, forces IDLE at the next edge:
  - `out_valid`, `in_ready` and `im_en` drop.
  - no `done` pulse.
  - counter and error state are retained until the next `start`.
- `abort` has priority over every other transition.
- `start` outside IDLE is ignored.
- `im_en`=0 outside LOOKUP. `im_qlevel` holds its last value.

## Timing
- Reset (`nrst`=0 at an edge): state IDLE; `busy`, `done`, `in_ready`, `im_en`, `out_valid`, `out_last`, `err_level` = 0; `im_qlevel`, `out_hv`, `out_idx`, `err_count`, counter = 0.
- Reset mid-frame behaves identically. A partial frame is discarded.
- Latency: input handshake at edge N → `im_en` high during cycle N+1 → `out_valid` high from cycle N+2.
- Peak throughput: one feature per 3 cycles with `in_valid` and `out_ready` held high.
- A frame with no stalls takes 3·NUM_FEATURES + 1 cycles from `start` to the `done` cycle.
- `in_ready` and `out_valid` are never high in the same cycle. There is no bypass.
- Handshakes are registered. The controller never withdraws `out_valid` without a handshake, except on `abort` or reset.

## Test plan
- **Nominal frame:** NUM_FEATURES=16; levels 0..9,0..5; `in_valid` and `out_ready` always 1.
  - `out_hv` sequence 0x000..0x009, 0x000..0x005; `out_idx` 0..15.
  - `out_last` only at idx 15.
  - `done` 49 cycles after `start`; `err_count`=0.
- **Out-of-range levels:** levels 10, 15, 9 within a frame.
  - the first two emit `out_hv`=0; 9 emits 0x009.
  - `err_level`=1, `err_count`=2 after the frame; both cleared on the next `start`.
- **Backpressure:** `out_ready` held 0 for 5 cycles at idx 3.
  - `out_valid`, `out_hv`, `out_idx`=3 stable throughout.
  - `in_ready`=0 throughout; no feature skipped or duplicated.
- **Abort:** `abort` asserted in EMIT at idx 7.
  - IDLE next cycle; `out_valid`=0; no `done`.
  - A following `start` restarts at idx 0 with errors cleared.
- **Reset mid-frame:** `nrst`=0 for 1 cycle during LOOKUP.
  - All outputs at reset values next cycle.
  - `start` is then accepted normally.
- **Ignored start:** `start` pulsed during WAIT_IN and EMIT → no counter reset, frame completes normally.
- **Saturation:** 300 out-of-range levels with NUM_FEATURES=300 → `err_count` holds at 255.
